// File: rtl/bn_issue.sv
// Issue sequencer for the batch-norm datapath: pairs each streamed activation
// with its channel coefficients, issues it, and tracks returns until the frame drains.
module bn_issue #(
  parameter int unsigned D_WL  = 24,
  parameter int unsigned FL    = 16,
  parameter int unsigned CH_N  = 16,
  parameter int unsigned CH_AW = 4,
  parameter int unsigned PIX_W = 16
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [CH_AW-1:0]        cfg_addr,
  input  logic signed [D_WL-1:0]  cfg_a,
  input  logic signed [D_WL-1:0]  cfg_b,
  input  logic                    start,
  input  logic [PIX_W-1:0]        pix_num,
  input  logic                    in_valid,
  input  logic signed [D_WL-1:0]  in_data,
  output logic                    in_ready,
  output logic signed [D_WL-1:0]  bn_d_in,
  output logic signed [D_WL-1:0]  bn_a,
  output logic signed [D_WL-1:0]  bn_b,
  output logic                    bn_en,
  input  logic                    bn_o_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned TOT_W = PIX_W + CH_AW;

  // Coefficients are kept in the datapath's Q(D_WL-FL).FL format.
  typedef struct packed {
    logic [D_WL-FL-1:0] ip;
    logic [FL-1:0]      fp;
  } fix_t;

  typedef struct packed {
    fix_t a;
    fix_t b;
  } coef_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [TOT_W-1:0]   iss_q, iss_d;
  logic [TOT_W-1:0]   ret_q, ret_d;
  logic [CH_AW-1:0]   ch_q, ch_d;
  coef_t              tab_q [CH_N];
  logic               hs;
  logic               tab_we;

  assign hs     = in_valid && in_ready;
  assign tab_we = cfg_we && !busy && (32'(cfg_addr) < CH_N);

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; transitions look at the counters' next values
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (pix_num == '0) ? S_DONE : S_RUN;
      S_RUN:   if (iss_d == total_q) state_d = S_DRAIN;
      S_DRAIN: if (ret_d == total_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
    in_ready = (state_q == S_RUN) && (iss_q < total_q);
  end

  // Frame counters; the return count saturates at the frame total
  always_comb begin
    total_d = total_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    ch_d    = ch_q;
    if ((state_q == S_IDLE) && start) begin
      total_d = TOT_W'(pix_num) * TOT_W'(CH_N);
      iss_d   = '0;
      ret_d   = '0;
      ch_d    = '0;
    end else begin
      if (hs) begin
        iss_d = iss_q + TOT_W'(1);
        ch_d  = (ch_q == CH_AW'(CH_N - 1)) ? '0 : ch_q + CH_AW'(1);
      end
      if (bn_o_valid && (ret_q < total_q)) ret_d = ret_q + TOT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      ch_q    <= '0;
    end else begin
      total_q <= total_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      ch_q    <= ch_d;
    end
  end

  // Coefficient table, writable only outside a frame
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_N; i++) tab_q[i] <= '0;
    end else if (tab_we) begin
      tab_q[cfg_addr] <= {cfg_a, cfg_b};
    end
  end

  // Issue stage: one bn_en beat per accepted activation, payload held otherwise
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bn_en   <= 1'b0;
      bn_d_in <= '0;
      bn_a    <= '0;
      bn_b    <= '0;
    end else begin
      bn_en <= hs;
      if (hs) begin
        bn_d_in <= in_data;
        bn_a    <= tab_q[ch_q].a;
        bn_b    <= tab_q[ch_q].b;
      end
    end
  end

endmodule

// File: tb/tb_bn_issue.sv
// Directed bench for bn_issue with a 3-cycle-latency batch-norm datapath model.
module tb_bn_issue;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [23:0] cfg_a = '0;
  logic [23:0] cfg_b = '0;
  logic        start = 1'b0;
  logic [15:0] pix_num = '0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready;
  logic [23:0] bn_d_in;
  logic [23:0] bn_a;
  logic [23:0] bn_b;
  logic        bn_en;
  logic        bn_o_valid;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_bad = 0;
  int ret_seen = 0;
  logic [23:0] exp_a [16];
  logic [23:0] exp_b [16];
  logic [2:0]  sr;

  always #5 CLK = ~CLK;

  bn_issue dut (
    .CLK(CLK), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .start(start), .pix_num(pix_num),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bn_d_in(bn_d_in), .bn_a(bn_a), .bn_b(bn_b), .bn_en(bn_en),
    .bn_o_valid(bn_o_valid), .busy(busy), .done(done)
  );

  // Datapath model: result valid 3 cycles after each bn_en
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], bn_en};
  end
  assign bn_o_valid = sr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    ret_seen += int'(bn_o_valid);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(bn_en), 0);
    chk({tag, "_d"}, 32'(bn_d_in), 0);
    chk({tag, "_a"}, 32'(bn_a), 0);
    chk({tag, "_b"}, 32'(bn_b), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rdy"}, 32'(in_ready), 0);
  endtask

  task automatic wait_done(input int n);
    bit got;
    bit ed;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      ed = (bn_o_valid === 1'b1) && (ret_seen + 1 == n);
      tick();
      chk("done", 32'(done), 32'(ed));
      chk("busy", 32'(busy), 32'(!ed));
      got = ed;
    end
    n_chk++;
    assert (got) else begin
      n_bad++;
      $error("FAIL done_timeout: got returns=%0d want %0d", ret_seen, n);
    end
    tick();
    chk("done_clear", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  // Streams up to stop_at beats of an n_pix frame; poke injects a table write
  // and a stray start while the frame is running.
  task automatic run_frame(input int n_pix, input bit gaps, input int stop_at, input bit poke);
    int n, sent, ch, cyc;
    logic [23:0] d;
    bit hs;
    n = n_pix * 16;
    sent = 0; ch = 0; cyc = 0;
    ret_seen = 0;
    start = 1'b1; pix_num = 16'(n_pix);
    tick();
    start = 1'b0;
    chk("busy_on_start", 32'(busy), 1);
    chk("en_on_start", 32'(bn_en), 0);
    while (sent < n && sent < stop_at && cyc < 400) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = 24'($urandom);
      in_data = d;
      if (poke) begin
        cfg_we = (cyc == 5); cfg_addr = 4'd3; cfg_a = 24'h7FFFFF; cfg_b = 24'h123456;
        start = (cyc == 7); pix_num = 16'd5;
      end
      chk("in_ready", 32'(in_ready), 1);
      hs = in_valid;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      if (hs) begin
        chk("bn_en_hs", 32'(bn_en), 1);
        chk("bn_d_in", 32'(bn_d_in), 32'(d));
        chk("bn_a", 32'(bn_a), 32'(exp_a[ch]));
        chk("bn_b", 32'(bn_b), 32'(exp_b[ch]));
        sent++;
        ch = (ch + 1) % 16;
      end else begin
        chk("bn_en_gap", 32'(bn_en), 0);
      end
      cyc++;
    end
    n_chk++;
    assert (sent == n || sent == stop_at) else begin
      n_bad++;
      $error("FAIL stream_timeout: got %0d beats want %0d", sent, n);
    end
    if (sent == n) begin
      in_valid = 1'b1;
      chk("in_ready_drop", 32'(in_ready), 0);
      tick();
      chk("bn_en_after_last", 32'(bn_en), 0);
      in_valid = 1'b0;
      wait_done(n);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin exp_a[k] = '0; exp_b[k] = '0; end

    // Power-on reset
    tick(); tick();
    chk_all_zero("por");
    rst_n = 1'b1;
    tick();

    // Load entry k with A = k<<16, B = k
    for (int k = 0; k < 16; k++) begin
      cfg_we = 1'b1; cfg_addr = 4'(k); cfg_a = 24'(k << 16); cfg_b = 24'(k);
      exp_a[k] = 24'(k << 16); exp_b[k] = 24'(k);
      tick();
    end
    cfg_we = 1'b0;
    chk("idle_ready", 32'(in_ready), 0);

    // Gapless two-pixel frame
    run_frame(2, 1'b0, 1000, 1'b0);

    // Random gaps, with a table write and a stray start mid-frame
    run_frame(3, 1'b1, 1000, 1'b1);

    // Entry 3 must still hold its earlier value
    run_frame(1, 1'b0, 1000, 1'b0);

    // Zero-pixel frame
    in_valid = 1'b1;
    start = 1'b1; pix_num = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    chk("zero_rdy", 32'(in_ready), 0);
    chk("zero_en", 32'(bn_en), 0);
    tick();
    chk("zero_done_clear", 32'(done), 0);
    chk("zero_rdy2", 32'(in_ready), 0);
    chk("zero_en2", 32'(bn_en), 0);
    in_valid = 1'b0;

    // Abort after 10 beats with an asynchronous reset
    run_frame(2, 1'b0, 10, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin exp_a[k] = '0; exp_b[k] = '0; end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_abort_done", 32'(done), 0);
    end

    // Restart: table was cleared by reset
    run_frame(1, 1'b0, 1000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bn_issue.md
Name: bn_issue

Overview:
- Initiator-side sequencer for the batch-norm datapath; drives its D_IN/A/B/bn_en inputs and consumes its BN_o_valid return.
- Holds a per-channel coefficient table (scale A, offset B). Accepts a ready/valid activation stream in channel-interleaved order: channel index is the inner loop, pixel index the outer loop.
- Pairs each accepted beat with its channel's coefficients and issues one bn_en beat.
- Counts returned results and signals completion once the whole frame has drained.

Parameters:
- D_WL, 24, data/coefficient word length (signed fixed point).
- FL, 16, fractional bits. Carried through only, so coefficients match the datapath format.
- CH_N, 16, channels per pixel (number of coefficient table entries).
- CH_AW, 4, channel index width, ceil(log2(CH_N)).
- PIX_W, 16, pixel-count width.

Ports:
- CLK, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_we, in, 1, coefficient table write strobe.
- cfg_addr, in, CH_AW, table write address.
- cfg_a, in, D_WL, signed scale written at cfg_addr.
- cfg_b, in, D_WL, signed offset written at cfg_addr.
- start, in, 1, single-cycle frame start.
- pix_num, in, PIX_W, pixels in the frame; sampled on start.
- in_valid, in, 1, activation beat valid.
- in_data, in, D_WL, signed activation.
- in_ready, out, 1, activation beat accepted when in_valid&in_ready.
- bn_d_in, out, D_WL, activation to the BN datapath.
- bn_a, out, D_WL, scale to the BN datapath.
- bn_b, out, D_WL, offset to the BN datapath.
- bn_en, out, 1, issue strobe to the BN datapath.
- bn_o_valid, in, 1, result-valid return from the BN datapath.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle frame-complete pulse.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is CLK.
  - While in reset, all outputs are 0, the FSM is in IDLE, all counters are 0, and all coefficient table entries are 0.
  - Reset asserted mid-frame aborts the frame. No done pulse is produced.
- Table write: on a cycle with cfg_we=1 and busy=0, entry cfg_addr takes {cfg_a, cfg_b}.
  - Writes while busy=1 are ignored.
  - cfg_addr >= CH_N is ignored.
- FSM states:
  - IDLE -> RUN on start=1. At that edge: latch total = pix_num*CH_N (width PIX_W+CH_AW), clear the issue count, clear the return count, clear the channel counter.
  - start=1 with pix_num=0 -> DONE directly.
  - RUN -> DRAIN when the issue count reaches total.
  - DRAIN -> DONE when the return count reaches total.
  - DONE -> IDLE after one cycle.
  - start while not in IDLE is ignored.
- busy = (state != IDLE) && (state != DONE), registered. done = (state == DONE).
- in_ready = (state == RUN) && (issue count < total). It is combinational from state and counters, not from in_valid.
- Issue path, for a handshake in cycle t:
  - In cycle t+1: bn_en=1, bn_d_in=in_data, bn_a/bn_b = table entry of the current channel. All are registered outputs.
  - bn_en=0 in every cycle not immediately following a handshake. bn_d_in/bn_a/bn_b hold their last value when bn_en=0.
  - Back-to-back handshakes give back-to-back bn_en cycles, with no bubbles.
- Channel counter: increments per handshake and wraps from CH_N-1 to 0. The pixel index is implicit in the issue count.
- Return path: each cycle with bn_o_valid=1 increments the return count.
  - The datapath returns results 3 cycles after bn_en (result in cycle t+4 for a handshake in cycle t).
  - The return count saturates at total. Extra bn_o_valid pulses are ignored and do not wrap the counter.
- Simultaneous events:
  - A handshake and a bn_o_valid in the same cycle update both counters.
  - The last issue and the last return cannot coincide. DRAIN is always occupied for at least 3 cycles.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> all outputs 0 asynchronously. After release, table entries read back 0 through bn_a/bn_b on the next frame.
- Basic frame, CH_N=16: write entry k with A=k<<16, B=k; start with pix_num=2; stream 32 beats with no gaps.
  - Required: bn_en high for exactly 32 consecutive cycles.
  - Required: bn_a/bn_b cycle 0..15 twice.
  - Required: with BN model attached, done pulses 1 cycle after the 32nd bn_o_valid; busy falls in that same cycle.
- Backpressure/gaps: random in_valid at 50% density, pix_num=3.
  - Required: bn_en occurs only the cycle after each handshake; channel order is preserved; exactly 48 issues.
  - Required: in_ready drops after the 48th handshake.
- Zero frame: start with pix_num=0 -> in_ready never asserts; done pulses 1 cycle after start; bn_en stays 0.
- Config while busy: cfg_we to entry 3 with A=0x7FFFFF during RUN -> ignored; entry 3 keeps its prior value for this frame and the next.
- Abort and restart: assert rst_n=0 after 10 of 32 beats, release, start with pix_num=1 -> no done for the aborted frame; new frame completes after 16 returns.
